obj_dma: RTL and testbench
==========================

# obj_dma

Object-list DMA engine; the responder on the far side of the `DMA_ON` I/O write strobe produced by the main-CPU I/O decode. A `DMA_ON` write arms the engine. At the next vertical-blank start it copies the object RAM into the object line buffer's private copy, one 16-bit word per enabled clock. Sprite hardware therefore renders a stable list while the CPU edits the next one.

## Interface
- `WORDS`, 512: number of 16-bit object words copied per transfer; must be a power of two, 2..1024.
- `AW`, 9: address width; must equal log2(`WORDS`).

- `CLK_32M`  in  1  system clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `ce`  in  1  clock enable; the FSM, edge detectors and pipeline advance only when `ce`=1.
- `DMA_ON`  in  1  decoded I/O-write strobe; level, may stay high for any number of cycles.
- `vblank`  in  1  vertical blank, synchronous to `CLK_32M`.
- `src_addr`  out  AW  object RAM read address; synchronous RAM, data valid 1 `ce` later.
- `src_data`  in  16  object RAM read data.
- `dst_addr`  out  AW  buffer write address.
- `dst_data`  out  16  buffer write data.
- `dst_we`  out  1  buffer write enable, one `ce` per word.
- `busy`  out  1  high while state is COPY or FLUSH.
- `armed`  out  1  high while state is ARMED.
- `dma_done`  out  1  one-`ce` pulse after the last word is written.

## Operation
- Edge detection: `dma_rise` = `DMA_ON` & ~`DMA_ON`_q. `vb_rise` = `vblank` & ~`vblank`_q. Both `_q` registers update on `ce` only.
- States: IDLE, ARMED, COPY, FLUSH.
  - IDLE: on `dma_rise` go to ARMED.
  - ARMED: on `vb_rise` go to COPY with `rd_ptr`=0. If `vblank` is already high when arming, wait for the next rising edge; never start mid-blank.
  - COPY: each `ce` puts `src_addr`=`rd_ptr`, then `rd_ptr`++. When `rd_ptr`=`WORDS`-1 has been issued, go to FLUSH.
  - FLUSH: one `ce` for the final write, then return to IDLE. If `pending` is set, go to ARMED instead and clear `pending`.
- Write pipeline: a stage register holds `wr_valid`/`wr_addr`, delayed one `ce` from the read issue. `dst_we`=`wr_valid`, `dst_addr`=`wr_addr`, `dst_data`=`src_data` (RAM output, combinational pass-through).
- `pending`:
  - Set by a `dma_rise` during COPY or FLUSH.
  - Cleared when it causes re-arm.
  - `dma_rise` in ARMED has no effect.
  - Simultaneous `dma_rise` and FLUSH exit: go to ARMED.
- `rd_ptr` is AW+1 bits internally; the wrap at `WORDS` is never used as an address.
- `dma_done` is asserted on the FLUSH `ce`, alongside the final write.
- Deasserting `vblank` during COPY does not abort the transfer; software guarantees that blank is at least `WORDS`+1 `ce` long.
- `ce`=0 freezes all state and outputs except `dst_we`. `dst_we` is gated: `dst_we` = `wr_valid` & `ce`.

## Timing
- Reset (async, immediate, including mid-copy):
  - State IDLE; `pending`=0; `rd_ptr`=0; `wr_valid`=0.
  - `src_addr`=0, `dst_addr`=0, `dst_we`=0, `busy`=0, `armed`=0, `dma_done`=0.
  - `DMA_ON`_q and `vblank`_q reset to 1, so a level that is already high at reset release is not seen as an edge.
  - A partial buffer is left as-is.
- With `ce`=1 every cycle:
  - `DMA_ON` rises at edge t: `armed`=1 after edge t+1.
  - `vblank` rises at edge v: COPY entered at v+1, with `src_addr`=0 and `busy`=1.
  - First `dst_we` (address 0) at v+2.
  - Last read (`WORDS`-1) issued at v+`WORDS`; its write and `dma_done` at v+`WORDS`+1.
  - `busy` falls at v+`WORDS`+2.
  - Total `busy` length is `WORDS`+1 cycles.
- Throughput: one word per `ce`; no bubbles.

## Test plan
- Basic copy, `WORDS`=512:
  - Stimulus: fill source RAM with `data[i]`=i^16'hA5A5; pulse `DMA_ON`; raise `vblank`.
  - Required: exactly 512 `dst_we` pulses, addresses 0..511 in order, each `dst_data`=i^16'hA5A5.
  - Required: `dma_done` pulses once, coincident with the write to 511.
  - Required: `busy` high for exactly 513 cycles.
- Arm during blank:
  - Stimulus: `DMA_ON` rises while `vblank`=1.
  - Required: no write until `vblank` falls and rises again; then a normal 512-word copy.
- Re-arm during copy:
  - Stimulus: `DMA_ON` rises at copy word 100.
  - Required: after the copy, `armed`=1 and `busy`=0.
  - Required: the next `vblank` rise triggers a second full copy; total 1024 writes.
- Held level / repeats:
  - Stimulus: `DMA_ON` held high for 50 cycles; a second `DMA_ON` pulse while ARMED.
  - Required: a single transfer.
  - Required: `pending`=0 after it (no second copy on the following blank).
- `ce` throttling:
  - Stimulus: `ce` active 1 cycle in 4 during a copy.
  - Required: same 512 writes with correct data.
  - Required: `dst_we` only on `ce` cycles; `busy` spans 513 `ce` pulses.
- Reset mid-copy:
  - Stimulus: `reset_n` driven low asynchronously at word 200.
  - Required: `dst_we`/`busy`/`armed`/`dma_done` drop to 0 with no clock edge.
  - Required: after release, a `vblank` rise alone causes no writes; a new `DMA_ON` plus `vblank` rise gives a full copy from 0.

Source files
------------

// File: rtl/obj_dma.sv
// obj_dma: object-list DMA engine.
// A DMA_ON strobe arms the engine; the next vblank rising edge starts a copy
// of WORDS 16-bit words from the object RAM into the line buffer's private
// copy, one word per enabled clock. A DMA_ON edge during a copy is remembered
// and re-arms the engine as soon as the current copy finishes.
module obj_dma #(
    parameter int WORDS = 512,
    parameter int AW    = 9
) (
    input  logic          CLK_32M,
    input  logic          reset_n,
    input  logic          ce,
    input  logic          DMA_ON,
    input  logic          vblank,
    output logic [AW-1:0] src_addr,
    input  logic [15:0]   src_data,
    output logic [AW-1:0] dst_addr,
    output logic [15:0]   dst_data,
    output logic          dst_we,
    output logic          busy,
    output logic          armed,
    output logic          dma_done
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_COPY  = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    // Read pointer carries one extra bit so the terminal count is explicit;
    // only the low AW bits ever reach the RAM address.
    localparam logic [AW:0] LAST_PTR = (AW+1)'(WORDS - 1);

    logic [1:0]    state_reg,    state_next;
    logic          pending_reg,  pending_next;
    logic [AW:0]   rd_ptr_reg,   rd_ptr_next;
    logic          wr_valid_reg, wr_valid_next;
    logic [AW-1:0] wr_addr_reg,  wr_addr_next;
    logic          dma_q_reg;
    logic          vb_q_reg;

    logic dma_rise;
    logic vb_rise;

    assign dma_rise = DMA_ON & ~dma_q_reg;
    assign vb_rise  = vblank & ~vb_q_reg;

    // Next-state logic: arm, wait for blank start, stream reads, drain the
    // final write, then idle or re-arm if another request arrived meanwhile.
    always_comb begin
        state_next    = state_reg;
        pending_next  = pending_reg;
        rd_ptr_next   = rd_ptr_reg;
        wr_valid_next = 1'b0;
        wr_addr_next  = wr_addr_reg;
        case (state_reg)
            ST_IDLE: begin
                if (dma_rise) begin
                    state_next = ST_ARMED;
                end
            end
            ST_ARMED: begin
                // Only a fresh rising edge starts a copy, never mid-blank.
                if (vb_rise) begin
                    state_next  = ST_COPY;
                    rd_ptr_next = '0;
                end
            end
            ST_COPY: begin
                wr_valid_next = 1'b1;
                wr_addr_next  = rd_ptr_reg[AW-1:0];
                rd_ptr_next   = rd_ptr_reg + 1'b1;
                if (dma_rise) begin
                    pending_next = 1'b1;
                end
                if (rd_ptr_reg == LAST_PTR) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                rd_ptr_next  = '0;
                pending_next = 1'b0;
                // A request arriving on this very cycle counts as pending too.
                if (pending_reg || dma_rise) begin
                    state_next = ST_ARMED;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State registers; everything advances only on clock-enable cycles.
    // Edge-detect history resets high so a level already present at reset
    // release is not mistaken for an edge.
    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= ST_IDLE;
            pending_reg  <= 1'b0;
            rd_ptr_reg   <= '0;
            wr_valid_reg <= 1'b0;
            wr_addr_reg  <= '0;
            dma_q_reg    <= 1'b1;
            vb_q_reg     <= 1'b1;
        end else if (ce) begin
            state_reg    <= state_next;
            pending_reg  <= pending_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_valid_reg <= wr_valid_next;
            wr_addr_reg  <= wr_addr_next;
            dma_q_reg    <= DMA_ON;
            vb_q_reg     <= vblank;
        end
    end

    // Write data comes straight from the RAM output, which lines up with the
    // write stage one enabled clock after the read was issued.
    assign src_addr = rd_ptr_reg[AW-1:0];
    assign dst_addr = wr_addr_reg;
    assign dst_data = src_data;
    assign dst_we   = wr_valid_reg & ce;
    assign busy     = (state_reg == ST_COPY) || (state_reg == ST_FLUSH);
    assign armed    = (state_reg == ST_ARMED);
    assign dma_done = (state_reg == ST_FLUSH);

endmodule

// File: tb/tb_obj_dma.sv
// tb_obj_dma: self-checking bench for obj_dma.
// A table of copy scenarios is applied in a loop; hand-written sequences cover
// re-arm during copy, re-arm coincident with FLUSH exit and reset mid-copy.
// Expected writes are queued when a copy is triggered and popped as the DUT
// writes them; outputs are sampled on the falling clock edge.
module tb_obj_dma;

    localparam int WORDS = 512;
    localparam int AW    = 9;

    logic          clk;
    logic          reset_n;
    logic          ce;
    logic          dma_on;
    logic          vblank;
    logic [AW-1:0] src_addr;
    logic [15:0]   src_data;
    logic [AW-1:0] dst_addr;
    logic [15:0]   dst_data;
    logic          dst_we;
    logic          busy;
    logic          armed;
    logic          dma_done;

    obj_dma #(.WORDS(WORDS), .AW(AW)) dut (
        .CLK_32M  (clk),
        .reset_n  (reset_n),
        .ce       (ce),
        .DMA_ON   (dma_on),
        .vblank   (vblank),
        .src_addr (src_addr),
        .src_data (src_data),
        .dst_addr (dst_addr),
        .dst_data (dst_data),
        .dst_we   (dst_we),
        .busy     (busy),
        .armed    (armed),
        .dma_done (dma_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Object RAM model: synchronous read, advancing only on enabled clocks.
    logic [15:0] src_mem [WORDS];
    initial src_data = 16'h0000;
    always @(posedge clk) begin
        if (ce) src_data <= src_mem[src_addr];
    end

    typedef struct {
        int ce_period;
        bit arm_in_blank;
        int hold;
        bit extra_pulse;
        int exp_writes;
        int exp_busy;
        int exp_done;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } exp_t;

    vec_t vecs [4];
    exp_t sb [$];
    exp_t mon_e;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int cyc = 0;
    int ce_period = 1;
    bit last_ce = 1'b0;
    int wb, bb, db;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Falling-edge monitor: consume expected writes and count busy/done.
    task automatic sample();
        last_ce = ce;
        if (dst_we === 1'b1) begin
            check("we_only_on_ce", 32'(ce), 32'd1);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: actual addr=%0d required=no write", dst_addr);
            end else begin
                mon_e = sb.pop_front();
                check("dst_addr", 32'(dst_addr), 32'(mon_e.addr));
                check("dst_data", 32'(dst_data), 32'(mon_e.data));
            end
            check("done_with_last_write", 32'(dma_done), 32'(dst_addr == AW'(WORDS - 1)));
            wr_cnt++;
        end
        if (dma_done === 1'b1 && ce === 1'b1) begin
            done_cnt++;
            check("done_has_write", 32'(dst_we), 32'd1);
        end
        if (busy === 1'b1 && ce === 1'b1) busy_cnt++;
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        ce = (ce_period <= 1) || ((cyc % ce_period) == 0);
    endtask

    task automatic ce_steps(input int n);
        int k;
        k = 0;
        while (k < n) begin
            step();
            if (last_ce) k++;
        end
    endtask

    task automatic wait_writes(input int base, input int n);
        int k;
        k = 0;
        while ((wr_cnt - base) < n && k < 4000) begin
            step();
            k++;
        end
        check("reach_write_count", 32'((wr_cnt - base) >= n), 32'd1);
    endtask

    task automatic push_copy();
        exp_t e;
        for (int i = 0; i < WORDS; i++) begin
            e.addr = AW'(i);
            e.data = 16'(i) ^ 16'hA5A5;
            sb.push_back(e);
        end
    endtask

    task automatic pulse_dma();
        dma_on = 1'b1;
        ce_steps(1);
        dma_on = 1'b0;
        ce_steps(2);
    endtask

    task automatic mark();
        wb = wr_cnt;
        bb = busy_cnt;
        db = done_cnt;
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) src_mem[i] = 16'(i) ^ 16'hA5A5;

        //          period blank hold extra writes busy done
        vecs[0] = '{1, 1'b0, 1,  1'b0, 512, 513, 1};
        vecs[1] = '{1, 1'b1, 1,  1'b0, 512, 513, 1};
        vecs[2] = '{1, 1'b0, 50, 1'b1, 512, 513, 1};
        vecs[3] = '{4, 1'b0, 1,  1'b0, 512, 513, 1};

        reset_n = 1'b0;
        ce      = 1'b1;
        dma_on  = 1'b0;
        vblank  = 1'b0;
        step();
        step();
        check("reset_outputs", 32'({src_addr, dst_addr, dst_we, busy, armed, dma_done}), 32'd0);
        reset_n = 1'b1;
        ce_steps(3);
        check("idle_after_reset", 32'({busy, armed}), 32'd0);

        // Table-driven copy scenarios.
        for (int s = 0; s < 4; s++) begin
            ce_period = vecs[s].ce_period;
            mark();
            if (vecs[s].arm_in_blank) begin
                vblank = 1'b1;
                ce_steps(3);
            end
            dma_on = 1'b1;
            ce_steps(vecs[s].hold);
            dma_on = 1'b0;
            ce_steps(2);
            check("armed_after_dma_on", 32'(armed), 32'd1);
            if (vecs[s].extra_pulse) pulse_dma();
            if (vecs[s].arm_in_blank) begin
                ce_steps(10);
                check("no_write_mid_blank", 32'(wr_cnt - wb), 32'd0);
                vblank = 1'b0;
                ce_steps(3);
            end
            push_copy();
            vblank = 1'b1;
            ce_steps(WORDS + 8);
            check("busy_low_after_copy", 32'(busy), 32'd0);
            check("armed_low_after_copy", 32'(armed), 32'd0);
            check("write_count", 32'(wr_cnt - wb), 32'(vecs[s].exp_writes));
            check("busy_length", 32'(busy_cnt - bb), 32'(vecs[s].exp_busy));
            check("done_count", 32'(done_cnt - db), 32'(vecs[s].exp_done));
            check("scoreboard_empty", 32'(sb.size()), 32'd0);
            // The following blank must not start another copy.
            vblank = 1'b0;
            ce_steps(3);
            vblank = 1'b1;
            ce_steps(20);
            check("no_repeat_copy", 32'(wr_cnt - wb), 32'(vecs[s].exp_writes));
            vblank = 1'b0;
            ce_steps(2);
            $display("copy %0d: ce_period=%0d writes=%0d busy=%0d done=%0d",
                     s, ce_period, wr_cnt - wb, busy_cnt - bb, done_cnt - db);
        end

        // Re-arm during copy, then re-arm coincident with FLUSH exit.
        ce_period = 1;
        ce = 1'b1;
        mark();
        pulse_dma();
        push_copy();
        vblank = 1'b1;
        wait_writes(wb, 100);
        dma_on = 1'b1;
        ce_steps(1);
        dma_on = 1'b0;
        ce_steps(WORDS);
        check("rearm_busy_low", 32'(busy), 32'd0);
        check("rearm_armed", 32'(armed), 32'd1);
        vblank = 1'b0;
        ce_steps(3);
        push_copy();
        vblank = 1'b1;
        begin
            int k;
            k = 0;
            while (dma_done !== 1'b1 && k < 2000) begin
                step();
                k++;
            end
        end
        check("second_copy_done_seen", 32'(dma_done), 32'd1);
        dma_on = 1'b1;
        step();
        dma_on = 1'b0;
        check("flush_exit_rearm", 32'({busy, armed}), 32'd1);
        vblank = 1'b0;
        ce_steps(3);
        push_copy();
        vblank = 1'b1;
        ce_steps(WORDS + 8);
        check("rearm_total_writes", 32'(wr_cnt - wb), 32'(3 * WORDS));
        check("rearm_done_count", 32'(done_cnt - db), 32'd3);
        check("rearm_scoreboard_empty", 32'(sb.size()), 32'd0);
        vblank = 1'b0;
        ce_steps(3);
        vblank = 1'b1;
        ce_steps(20);
        check("rearm_no_fourth_copy", 32'(wr_cnt - wb), 32'(3 * WORDS));
        vblank = 1'b0;
        ce_steps(2);
        $display("rearm sequence: writes=%0d done=%0d", wr_cnt - wb, done_cnt - db);

        // Reset mid-copy.
        mark();
        pulse_dma();
        push_copy();
        vblank = 1'b1;
        wait_writes(wb, 200);
        #1;
        reset_n = 1'b0;
        #1;
        check("reset_async_we", 32'(dst_we), 32'd0);
        check("reset_async_busy", 32'(busy), 32'd0);
        check("reset_async_armed", 32'(armed), 32'd0);
        check("reset_async_done", 32'(dma_done), 32'd0);
        sb.delete();
        ce_steps(3);
        reset_n = 1'b1;
        ce_steps(3);
        vblank = 1'b0;
        ce_steps(3);
        mark();
        vblank = 1'b1;
        ce_steps(20);
        check("no_copy_without_arm", 32'(wr_cnt - wb), 32'd0);
        check("not_armed_after_reset", 32'(armed), 32'd0);
        vblank = 1'b0;
        ce_steps(3);
        pulse_dma();
        push_copy();
        vblank = 1'b1;
        ce_steps(WORDS + 8);
        check("post_reset_writes", 32'(wr_cnt - wb), 32'(WORDS));
        check("post_reset_busy", 32'(busy_cnt - bb), 32'(WORDS + 1));
        check("post_reset_scoreboard_empty", 32'(sb.size()), 32'd0);
        vblank = 1'b0;
        ce_steps(2);
        $display("reset sequence: writes=%0d busy=%0d", wr_cnt - wb, busy_cnt - bb);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
